if_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 51 +++++
 rtl/if_stage.sv | 159 +++++++++++++++
 tb/tb_if_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the RV32I pipeline front end.
//   NOP_INSN          : bubble encoding (addi x0,x0,0) loaded into IF/ID
//   RESET_PC_DEFAULT  : default PC of the first fetch after reset
//   fetch_state_t     : fetch FSM states (S_REQ / S_WAIT / S_HOLD)
//   id_ctl_t          : IF/ID register control (hold / load / flush)
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    ID_HOLD,
    ID_LOAD,
    ID_FLUSH
  } id_ctl_t;

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// 64-bit IF/ID pipeline register feeding the decode stage.
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset (loads a bubble)
//   ctl        in   ID_HOLD keeps contents, ID_LOAD captures load_pc/load_insn,
//                   ID_FLUSH inserts a bubble
//   load_pc    in   PC of the instruction being loaded
//   load_insn  in   instruction being loaded
//   insn       out  registered instruction
//   pc         out  registered PC
// -----------------------------------------------------------------------------
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] FLUSH_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  id_ctl_t     ctl,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_insn,
  output logic [31:0] insn,
  output logic [31:0] pc
);

  // A bubble carries PC 0 so that it looks identical to the post-reset state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      insn <= FLUSH_INSN;
      pc   <= '0;
    end else begin
      case (ctl)
        ID_LOAD: begin
          insn <= load_insn;
          pc   <= load_pc;
        end
        ID_FLUSH: begin
          insn <= FLUSH_INSN;
          pc   <= '0;
        end
        default: begin
          insn <= insn;
          pc   <= pc;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to a
// variable-latency instruction memory and drives the IF/ID register.
// Ports:
//   clk             in   clock
//   rst_n           in   synchronous active-low reset
//   IFWrite         in   0 = decode stalled, hold PC and IF/ID
//   Branch, Jump    in   taken branch / jump from decode
//   JumpAddr        in   redirect target from decode
//   imem_req        out  fetch request, accepted in the cycle it is high
//   imem_addr       out  word-aligned fetch address
//   imem_rvalid     in   fetch response valid
//   imem_rdata      in   fetched instruction
//   Instruction_id  out  IF/ID instruction
//   PC_id           out  IF/ID PC
// -----------------------------------------------------------------------------
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSN = pipe_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_t state, next_state;
  logic [31:0]  pc_if, pc_next, pc_plus4, target;
  logic [31:0]  hold_buf, hold_next;
  logic         kill, kill_next;
  logic         redirect;
  logic         req;
  logic [31:0]  addr;
  id_ctl_t      id_ctl;
  logic [31:0]  load_insn;

  // A redirect seen while decode is stalled is ignored; decode re-presents it.
  assign redirect = (Branch | Jump) & IFWrite;
  assign target   = JumpAddr & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_if + 32'd4;

  assign imem_req  = req & rst_n;
  assign imem_addr = addr;

  // On reset, an outstanding request may still be answered after release, so
  // kill is armed to drop that stale response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_if    <= RESET_PC_ALIGNED;
      state    <= S_REQ;
      kill     <= (state == S_WAIT);
      hold_buf <= '0;
    end else begin
      pc_if    <= pc_next;
      state    <= next_state;
      kill     <= kill_next;
      hold_buf <= hold_next;
    end
  end

  always_comb begin
    next_state = state;
    pc_next    = pc_if;
    kill_next  = kill;
    hold_next  = hold_buf;
    req        = 1'b0;
    addr       = pc_if;
    id_ctl     = ID_HOLD;
    load_insn  = imem_rdata;

    unique case (state)
      S_REQ: begin
        req        = 1'b1;
        next_state = S_WAIT;
        if (redirect) begin
          addr    = target;
          pc_next = target;
        end
        if (IFWrite) id_ctl = ID_FLUSH;
      end

      S_WAIT: begin
        if (!imem_rvalid) begin
          if (IFWrite) id_ctl = ID_FLUSH;
          // The request in flight belongs to the old stream; mark it for discard.
          if (redirect) begin
            pc_next   = target;
            kill_next = 1'b1;
          end
        end else if (kill || redirect) begin
          kill_next = 1'b0;
          req       = 1'b1;
          if (redirect) begin
            pc_next = target;
            addr    = target;
            id_ctl  = ID_FLUSH;
          end else if (IFWrite) begin
            id_ctl = ID_FLUSH;
          end
        end else if (IFWrite) begin
          id_ctl  = ID_LOAD;
          pc_next = pc_plus4;
          req     = 1'b1;
          addr    = pc_plus4;
        end else begin
          hold_next  = imem_rdata;
          next_state = S_HOLD;
        end
      end

      S_HOLD: begin
        if (IFWrite) begin
          next_state = S_WAIT;
          req        = 1'b1;
          if (redirect) begin
            id_ctl  = ID_FLUSH;
            pc_next = target;
            addr    = target;
          end else begin
            id_ctl    = ID_LOAD;
            load_insn = hold_buf;
            pc_next   = pc_plus4;
            addr      = pc_plus4;
          end
        end
      end

      default: begin
        next_state = S_REQ;
      end
    endcase
  end

  if_id_reg #(
    .FLUSH_INSN(NOP_INSN)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctl      (id_ctl),
    .load_pc  (pc_if),
    .load_insn(load_insn),
    .insn     (Instruction_id),
    .pc       (PC_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. The bench plays both the decode stage and
// a single-outstanding instruction memory with programmable latency. A
// decode-side reference model tracks which PC must be delivered next and
// checks every IF/ID update against the program image.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        IFWrite;
  logic        Branch;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_id;
  logic [31:0] PC_id;

  int checks;
  int failures;

  // memory model: one slot, requests arriving while busy are ignored
  logic        slot_busy;
  logic [31:0] slot_addr;
  int          slot_cnt;
  int          lat;

  logic        last_req;
  logic [31:0] last_req_addr;

  // decode-side reference model
  logic [31:0] exp_pc;
  logic [31:0] prev_insn;
  logic [31:0] prev_pc;
  int          deliveries;

  if_stage #(
    .RESET_PC(RESET_PC),
    .NOP_INSN(NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IFWrite       (IFWrite),
    .Branch        (Branch),
    .Jump          (Jump),
    .JumpAddr      (JumpAddr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .Instruction_id(Instruction_id),
    .PC_id         (PC_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Program image: two fixed words at 0 and 4, a hash elsewhere whose low
  // seven bits (0x37) can never look like the bubble encoding.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    h = (a * 32'h9E37_79B1) ^ 32'hC3A5_1F00;
    return {h[31:7], 7'h37};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive decode + memory at the negedge, observe the fetch
  // request, advance the memory, then check IF/ID against the model.
  task automatic applyStimulus(input logic rstv, input logic ifw, input logic br,
                               input logic jp, input logic [31:0] ja);
    logic        resp_now;
    logic        redirect;
    logic [31:0] tgt;
    rst_n    = rstv;
    IFWrite  = ifw;
    Branch   = br;
    Jump     = jp;
    JumpAddr = ja;
    resp_now    = slot_busy && (slot_cnt == 0);
    imem_rvalid = resp_now;
    imem_rdata  = resp_now ? memWord(slot_addr) : 32'hDEAD_BEEF;
    redirect    = rstv && ifw && (br || jp);
    tgt         = ja & 32'hFFFF_FFFC;
    #1;
    last_req      = imem_req;
    last_req_addr = imem_addr;
    if (!rstv) begin
      checkOutput("req_in_reset", {31'd0, imem_req}, 32'd0);
    end else if (imem_req) begin
      checkOutput("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (redirect) checkOutput("redirect_addr", imem_addr, tgt);
    end
    @(posedge clk);
    if (resp_now) slot_busy = 1'b0;
    else if (slot_busy) slot_cnt--;
    if (last_req && rstv && !slot_busy) begin
      slot_busy = 1'b1;
      slot_addr = last_req_addr;
      slot_cnt  = lat - 1;
    end
    @(negedge clk);
    if (!rstv) begin
      checkOutput("reset_insn", Instruction_id, NOP);
      checkOutput("reset_pc", PC_id, 32'd0);
      exp_pc = RESET_PC;
    end else if (!ifw) begin
      checkOutput("stall_insn", Instruction_id, prev_insn);
      checkOutput("stall_pc", PC_id, prev_pc);
    end else if (redirect) begin
      checkOutput("flush_insn", Instruction_id, NOP);
      exp_pc = tgt;
    end else if (Instruction_id !== NOP) begin
      checkOutput("deliver_pc", PC_id, exp_pc);
      checkOutput("deliver_insn", Instruction_id, memWord(exp_pc));
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    prev_insn = Instruction_id;
    prev_pc   = PC_id;
  endtask

  initial begin
    logic        ifw, br, jp;
    logic [31:0] ja;
    int          rand_start;
    checks      = 0;
    failures    = 0;
    slot_busy   = 1'b0;
    slot_addr   = '0;
    slot_cnt    = 0;
    lat         = 1;
    exp_pc      = RESET_PC;
    prev_insn   = NOP;
    prev_pc     = '0;
    deliveries  = 0;
    rst_n       = 1'b0;
    IFWrite     = 1'b1;
    Branch      = 1'b0;
    Jump        = 1'b0;
    JumpAddr    = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // back-to-back fetch with 1-cycle memory
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_req0", last_req_addr, 32'h0);
    checkOutput("t1_bubble", Instruction_id, NOP);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_req4", last_req_addr, 32'h4);
    checkOutput("t1_insn0", Instruction_id, 32'h0050_0093);
    checkOutput("t1_pc0", PC_id, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t1_req8", last_req_addr, 32'h8);
    checkOutput("t1_insn4", Instruction_id, 32'h00A0_0113);
    checkOutput("t1_pc4", PC_id, 32'h4);

    // decode stall while the PC 8 response returns
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_noreq_a", {31'd0, last_req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_noreq_b", {31'd0, last_req}, 32'd0);
    checkOutput("t2_held", Instruction_id, 32'h00A0_0113);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_req12", last_req_addr, 32'hC);
    checkOutput("t2_pc8", PC_id, 32'h8);

    // jump while the PC 0x10 response arrives
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_pc12", PC_id, 32'hC);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h103);
    checkOutput("t3_req100", last_req_addr, 32'h100);
    checkOutput("t3_bubble", Instruction_id, NOP);
    lat = 4;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t3_pc100", PC_id, 32'h100);

    // branch while the response is three cycles late
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h40);
    checkOutput("t4_noreq", {31'd0, last_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_bubble_a", Instruction_id, NOP);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_bubble_b", Instruction_id, NOP);
    lat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_req40", last_req_addr, 32'h40);
    checkOutput("t4_dropped", Instruction_id, NOP);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_pc40", PC_id, 32'h40);

    // branch during a stall is ignored, then taken when decode proceeds
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
    checkOutput("t5_noreq", {31'd0, last_req}, 32'd0);
    checkOutput("t5_pc_held", PC_id, 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
    checkOutput("t5_req200", last_req_addr, 32'h200);
    checkOutput("t5_bubble", Instruction_id, NOP);
    lat = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t5_pc200", PC_id, 32'h200);

    // reset while a request is in flight; the stale response follows release
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    lat = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_req_reset_pc", last_req_addr, RESET_PC);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_stale_dropped", Instruction_id, NOP);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_pc_reset", PC_id, RESET_PC);
    checkOutput("t6_insn0", Instruction_id, 32'h0050_0093);

    // randomized decode behaviour and memory latency, including targets near
    // the top of the address space so the PC wraps
    rand_start = deliveries;
    for (int i = 0; i < 800; i++) begin
      lat = $urandom_range(1, 3);
      ifw = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 11) == 0);
      jp  = ($urandom_range(0, 15) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      applyStimulus(1'b1, ifw, br, jp, ja);
    end
    checkOutput("random_progress", {31'd0, (deliveries - rand_start) >= 80}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
